// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and types for the register-file write arbiter slice.
package regfile_write_arbiter_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 3;

  localparam int REG_ZERO = 0;

  localparam logic REQ_ALU  = 1'b0;
  localparam logic REQ_LOAD = 1'b1;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_ALU  = 2'd1,
    GRANT_LOAD = 2'd2
  } grant_e;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request channels and register-file write port of the arbiter.
interface regfile_write_arbiter_if
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic                       req0_valid;
  logic                       req0_ready;
  logic [ADDR_WIDTH-1:0]      req0_dest;
  logic [DATA_WIDTH-1:0]      req0_data;

  logic                       req1_valid;
  logic                       req1_ready;
  logic [ADDR_WIDTH-1:0]      req1_dest;
  logic [DATA_WIDTH-1:0]      req1_data;

  logic                       wr_en;
  logic [ADDR_WIDTH-1:0]      wr_dest;
  logic [DATA_WIDTH-1:0]      wr_data;
  logic [2**ADDR_WIDTH-1:0]   pending;

  modport master (
    output req0_valid, req0_dest, req0_data,
    output req1_valid, req1_dest, req1_data,
    input  req0_ready, req1_ready,
    input  wr_en, wr_dest, wr_data, pending
  );

  modport slave (
    input  req0_valid, req0_dest, req0_data,
    input  req1_valid, req1_dest, req1_data,
    output req0_ready, req1_ready,
    output wr_en, wr_dest, wr_data, pending
  );

endinterface

// File: rtl/regfile_write_arbiter_wb_hold_buffer.sv
// One-entry writeback holding register. Load wins over clear so an entry
// drained on an edge can be refilled on that same edge.
module wb_hold_buffer
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] load_dest,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  full,
  output logic [ADDR_WIDTH-1:0] dest,
  output logic [DATA_WIDTH-1:0] data
);

  // Entry state: valid flag plus destination and data.
  always_ff @(posedge clock) begin
    if (reset) begin
      full <= 1'b0;
      dest <= {ADDR_WIDTH{1'b0}};
      data <= {DATA_WIDTH{1'b0}};
    end else if (load) begin
      full <= 1'b1;
      dest <= load_dest;
      data <= load_data;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between the ALU and load writeback
// paths, with one holding buffer per source and a pending-destination map.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input logic                    clock,
  input logic                    reset,
  regfile_write_arbiter_if.slave bus
);

  localparam int NUM_REGS = 2**ADDR_WIDTH;

  logic                  full0;
  logic                  full1;
  logic [ADDR_WIDTH-1:0] dest0;
  logic [ADDR_WIDTH-1:0] dest1;
  logic [DATA_WIDTH-1:0] data0;
  logic [DATA_WIDTH-1:0] data1;

  logic                  age;
  logic                  rr_last;
  grant_e                grant_sel;
  logic                  grant0;
  logic                  grant1;
  logic                  ready0;
  logic                  ready1;
  logic                  load0;
  logic                  load1;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_dest;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NUM_REGS-1:0]   pending;

  wb_hold_buffer #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_buf0 (
    .clock     (clock),
    .reset     (reset),
    .load      (load0),
    .clear     (grant0),
    .load_dest (bus.req0_dest),
    .load_data (bus.req0_data),
    .full      (full0),
    .dest      (dest0),
    .data      (data0)
  );

  wb_hold_buffer #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_buf1 (
    .clock     (clock),
    .reset     (reset),
    .load      (load1),
    .clear     (grant1),
    .load_dest (bus.req1_dest),
    .load_data (bus.req1_data),
    .full      (full1),
    .dest      (dest1),
    .data      (data1)
  );

  // Arbitration from registered state only; same-dest pairs keep program order.
  always_comb begin
    grant_sel = GRANT_NONE;
    if (reset) begin
      grant_sel = GRANT_NONE;
    end else if (full0 && !full1) begin
      grant_sel = GRANT_ALU;
    end else if (!full0 && full1) begin
      grant_sel = GRANT_LOAD;
    end else if (full0 && full1) begin
      if (dest0 == dest1) begin
        grant_sel = (age == REQ_LOAD) ? GRANT_LOAD : GRANT_ALU;
      end else begin
        grant_sel = (rr_last == REQ_ALU) ? GRANT_LOAD : GRANT_ALU;
      end
    end else begin
      grant_sel = GRANT_NONE;
    end
  end

  assign grant0 = (grant_sel == GRANT_ALU);
  assign grant1 = (grant_sel == GRANT_LOAD);

  // Ready is independent of valid; R0 writes are accepted but never buffered.
  assign ready0 = reset || !full0 || grant0;
  assign ready1 = reset || !full1 || grant1;
  assign load0  = bus.req0_valid && ready0 && (bus.req0_dest != ADDR_WIDTH'(REG_ZERO));
  assign load1  = bus.req1_valid && ready1 && (bus.req1_dest != ADDR_WIDTH'(REG_ZERO));

  // Write port mux; idle port is driven to zero.
  always_comb begin
    wr_en   = 1'b0;
    wr_dest = {ADDR_WIDTH{1'b0}};
    wr_data = {DATA_WIDTH{1'b0}};
    case (grant_sel)
      GRANT_ALU: begin
        wr_en   = 1'b1;
        wr_dest = dest0;
        wr_data = data0;
      end
      GRANT_LOAD: begin
        wr_en   = 1'b1;
        wr_dest = dest1;
        wr_data = data1;
      end
      default: begin
        wr_en   = 1'b0;
        wr_dest = {ADDR_WIDTH{1'b0}};
        wr_data = {DATA_WIDTH{1'b0}};
      end
    endcase
  end

  // Pending map: decoded destinations of every occupied buffer.
  always_comb begin
    pending = {NUM_REGS{1'b0}};
    if (reset) begin
      pending = {NUM_REGS{1'b0}};
    end else begin
      if (full0) begin
        pending[dest0] = 1'b1;
      end else begin
        pending = pending;
      end
      if (full1) begin
        pending[dest1] = 1'b1;
      end else begin
        pending = pending;
      end
    end
  end

  // Age bit names the older buffer; rr_last remembers the last granted side.
  always_ff @(posedge clock) begin
    if (reset) begin
      age     <= REQ_ALU;
      rr_last <= REQ_LOAD;
    end else begin
      if (load0 && load1) begin
        age <= REQ_ALU;
      end else if (load0 && full1 && !grant1) begin
        age <= REQ_LOAD;
      end else if (load1 && full0 && !grant0) begin
        age <= REQ_ALU;
      end else begin
        age <= age;
      end

      if (grant0) begin
        rr_last <= REQ_ALU;
      end else if (grant1) begin
        rr_last <= REQ_LOAD;
      end else begin
        rr_last <= rr_last;
      end
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.wr_en      = wr_en;
  assign bus.wr_dest    = wr_dest;
  assign bus.wr_data    = wr_data;
  assign bus.pending    = pending;

endmodule
